// File: rtl/serial_add_if.sv
// Handshake and operand/result bundle between a requester and serial_add_ctrl.
interface serial_add_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one mux-based full-adder cell is stepped over
// WIDTH cycles, LSB first, with the carry held in a flop between bits.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  S_IDLE | waiting for start; results from the last add are held
//  S_RUN  | one operand bit pair added per clock, sum shifts in from MSB
//  S_DONE | single-cycle done pulse; sum/cout/ovf are final
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    serial_add_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             ab_x;
    logic             cell_s;
    logic             cell_c;

    // Mux-based full-adder cell on the current LSBs and the carry flop.
    always_comb begin
        ab_x   = op_a_q[0] ^ op_b_q[0];
        cell_s = ab_x ? ~carry_q : carry_q;
        cell_c = ab_x ? carry_q : op_a_q[0];
    end

    // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        count_d = count_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_a_d  = bus.a;
                    op_b_d  = bus.b;
                    carry_d = bus.cin;
                    count_d = '0;
                    sum_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d   = (sum_q >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));
                op_a_d  = op_a_q >> 1;
                op_b_d  = op_b_q >> 1;
                carry_d = cell_c;
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    // carry_q here is the carry into the MSB
                    cout_d  = cell_c;
                    ovf_d   = carry_q ^ cell_c;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = (state_q == S_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances against an
// arithmetic reference model.
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_add_if #(.WIDTH(8)) bus8 ();
    serial_add_if #(.WIDTH(1)) bus1 ();

    serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));
    serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    // {ovf, cout, sum} from plain arithmetic; ovf from operand/result signs
    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] t;
        logic       v;
        t = {1'b0, a} + {1'b0, b} + 9'(c);
        v = (a[7] == b[7]) && (t[7] != a[7]);
        return {v, t};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf} !== 11'b0) begin
            errors++;
            $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf);
        end
        checks++;
        if ({bus1.busy, bus1.done, bus1.sum, bus1.cout, bus1.ovf} !== 5'b0) begin
            errors++;
            $display("FAIL reset1: got busy=%b done=%b sum=%b cout=%b ovf=%b, want all 0",
                     bus1.busy, bus1.done, bus1.sum, bus1.cout, bus1.ovf);
        end
        reset = 1'b0;
    endtask

    // One WIDTH=8 add; poke re-pulses start with new operands mid-run and during DONE.
    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input bit poke, input string name);
        logic [9:0] exp;
        int         cyc;
        bit         seen;
        exp = model8(a, b, c);
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = c;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
        checks++;
        if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after_start: got busy=%b done=%b, want 1 0", name, bus8.busy, bus8.done);
        end
        cyc = 0;
        seen = 0;
        while (cyc < 40 && !seen) begin
            if (poke && cyc == 2) begin
                bus8.start = 1'b1; bus8.a = ~a; bus8.b = ~b; bus8.cin = ~c;
            end else begin
                bus8.start = 1'b0;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus8.done === 1'b1) seen = 1;
        end
        bus8.start = 1'b0;
        checks++;
        if (!seen || cyc != 8) begin
            errors++;
            $display("FAIL %s latency: got done_seen=%0d after %0d edges, want done after 8", name, seen, cyc);
        end
        checks++;
        if ({bus8.ovf, bus8.cout, bus8.sum} !== exp) begin
            errors++;
            $display("FAIL %s result: got ovf=%b cout=%b sum=%h, want ovf=%b cout=%b sum=%h (a=%h b=%h cin=%b)",
                     name, bus8.ovf, bus8.cout, bus8.sum, exp[9], exp[8], exp[7:0], a, b, c);
        end
        if (poke) bus8.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        checks++;
        if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: got done=%b busy=%b, want 0 0", name, bus8.done, bus8.busy);
        end
        checks++;
        if ({bus8.ovf, bus8.cout, bus8.sum} !== exp) begin
            errors++;
            $display("FAIL %s hold: got ovf=%b cout=%b sum=%h, want %b %b %h",
                     name, bus8.ovf, bus8.cout, bus8.sum, exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic test_directed();
        add8(8'h05, 8'h03, 1'b0, 0, "add_05_03");
        add8(8'hFF, 8'h01, 1'b0, 0, "add_FF_01");
        add8(8'hFF, 8'hFF, 1'b1, 0, "add_FF_FF_c");
        add8(8'h7F, 8'h01, 1'b0, 0, "add_7F_01");
        add8(8'h80, 8'h80, 1'b0, 0, "add_80_80");
    endtask

    task automatic test_ignore_start();
        add8(8'h3C, 8'h5A, 1'b1, 1, "ignore_start");
    endtask

    task automatic test_reset_mid_run();
        int dones;
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h55; bus8.b = 8'h33; bus8.cin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf} !== 11'b0) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf);
        end
        dones = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset_abort: got %0d busy/done cycles after reset, want 0", dones);
        end
        add8(8'h55, 8'h33, 1'b1, 0, "after_reset");
    endtask

    task automatic test_width1();
        logic a, b, c, s_exp, c_exp, v_exp;
        int   cyc;
        bit   seen;
        for (int i = 0; i < 8; i++) begin
            a = 1'(i >> 2); b = 1'(i >> 1); c = 1'(i);
            {c_exp, s_exp} = 2'(a) + 2'(b) + 2'(c);
            v_exp = (a == b) && (s_exp != a);
            @(negedge clk);
            bus1.start = 1'b1; bus1.a = a; bus1.b = b; bus1.cin = c;
            @(posedge clk);
            @(negedge clk);
            bus1.start = 1'b0; bus1.a = ~a; bus1.b = ~b; bus1.cin = ~c;
            cyc = 0;
            seen = 0;
            while (cyc < 10 && !seen) begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
                if (bus1.done === 1'b1) seen = 1;
            end
            checks++;
            if (!seen || cyc != 1) begin
                errors++;
                $display("FAIL w1_latency case %0d: got done_seen=%0d after %0d edges, want 1", i, seen, cyc);
            end
            checks++;
            if ({bus1.ovf, bus1.cout, bus1.sum} !== {v_exp, c_exp, s_exp}) begin
                errors++;
                $display("FAIL w1_result case %0d: got ovf=%b cout=%b sum=%b, want %b %b %b",
                         i, bus1.ovf, bus1.cout, bus1.sum, v_exp, c_exp, s_exp);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_held_start();
        int pos[$];
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0;
        @(posedge clk);
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus8.done === 1'b1) pos.push_back(e);
        end
        bus8.start = 1'b0;
        checks++;
        if (pos.size() != 3 || pos[0] != 8 || pos[1] != 18 || pos[2] != 28) begin
            errors++;
            $display("FAIL held_start: got %0d done pulses (first at %0d), want 3 at edges 8,18,28",
                     pos.size(), (pos.size() > 0) ? pos[0] : -1);
        end
        repeat (12) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus8.sum !== 8'h46 || bus8.busy !== 1'b0) begin
            errors++;
            $display("FAIL held_result: got sum=%h busy=%b, want 46 0", bus8.sum, bus8.busy);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 30; i++)
            add8(8'($urandom), 8'($urandom), 1'($urandom), 0, "random");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid_run();
        test_width1();
        test_held_start();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
